hamming_router_q: RTL

//   Parametrised, registered successor of the Hamming(7,4) channel router.

---
 rtl/hamming_router_q.sv | 102 ++++++++++
 1 files changed

// File: rtl/hamming_router_q.sv
// rtl/hamming_router_q.sv - Hamming(7,4) encode/decode router with per-channel FIFOs
// Each channel FIFO entry holds {err, word[6:0]}; the head is masked to 0 when empty.
module hamming_router_q #(
   parameter int NCH   = 4,
   parameter int DEPTH = 2,
   parameter int ERR_W = 8,
   localparam int SELW = $clog2(NCH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [SELW-1:0]    in_sel,
   input  logic               in_dec,
   input  logic [6:0]         in_word,
   output logic [NCH-1:0]     out_valid,
   input  logic [NCH-1:0]     out_ready,
   output logic [NCH*7-1:0]   out_word,
   output logic [NCH-1:0]     out_err,
   input  logic               err_clr,
   output logic [ERR_W-1:0]   err_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [3:0]     d;
   logic [6:0]     enc_code;
   logic [6:0]     c;
   logic [6:0]     corr;
   logic [2:0]     syn;
   logic           syn_nz;
   logic [7:0]     entry;
   logic           accept;

   logic [7:0]     mem    [NCH][DEPTH];
   logic [AW-1:0]  wr_ptr [NCH];
   logic [AW-1:0]  rd_ptr [NCH];
   logic [CW-1:0]  cnt    [NCH];
   logic [NCH-1:0] push;
   logic [NCH-1:0] pop;

   always_comb begin
      d        = in_word[3:0];
      enc_code = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
      c        = in_word;
      syn      = {c[3] ^ c[4] ^ c[5] ^ c[6], c[1] ^ c[2] ^ c[5] ^ c[6], c[0] ^ c[2] ^ c[4] ^ c[6]};
      syn_nz   = (syn != 3'd0);
      corr     = c;
      // Syndrome value s points at bit position s-1 of the received word
      for (int i = 0; i < 7; i++) begin
         if (syn == 3'(i + 1)) corr[i] = ~c[i];
      end
      entry = in_dec ? {syn_nz, 3'b000, corr[6], corr[5], corr[4], corr[2]}
                     : {1'b0, enc_code};
   end

   // Readiness looks only at the stored count, never at out_ready
   assign in_ready = (cnt[in_sel] < CW'(DEPTH));
   assign accept   = in_valid & in_ready;

   always_comb begin
      push      = '0;
      pop       = '0;
      out_valid = '0;
      out_err   = '0;
      out_word  = '0;
      for (int k = 0; k < NCH; k++) begin
         push[k]            = accept && (in_sel == SELW'(k));
         out_valid[k]       = (cnt[k] != '0);
         pop[k]             = out_valid[k] & out_ready[k];
         out_word[7*k +: 7] = out_valid[k] ? mem[k][rd_ptr[k]][6:0] : 7'd0;
         out_err[k]         = out_valid[k] & mem[k][rd_ptr[k]][7];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NCH; k++) begin
            wr_ptr[k] <= '0;
            rd_ptr[k] <= '0;
            cnt[k]    <= '0;
         end
         err_cnt <= '0;
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (push[k]) begin
               mem[k][wr_ptr[k]] <= entry;
               wr_ptr[k]         <= wr_ptr[k] + AW'(1);
            end
            if (pop[k]) rd_ptr[k] <= rd_ptr[k] + AW'(1);
            if (push[k] && !pop[k])      cnt[k] <= cnt[k] + CW'(1);
            else if (pop[k] && !push[k]) cnt[k] <= cnt[k] - CW'(1);
         end
         if (err_clr)
            err_cnt <= '0;
         else if (accept && in_dec && syn_nz && (err_cnt != '1))
            err_cnt <= err_cnt + ERR_W'(1);
      end
   end

endmodule
